// File: rtl/tmds_channel_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tmds_channel_decoder_pkg: TMDS control tokens and decoder FSM states  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package tmds_channel_decoder_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_ALIGNED   = 2'd2
  } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/tmds_channel_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tmds_channel_decoder_if: word input, decoded outputs, slip request   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface tmds_channel_decoder_if;
  logic [9:0] din;
  logic [7:0] dout;
  logic       de;
  logic [1:0] ctrl;
  logic       bitslip;
  logic       aligned;

  modport master (output din, input dout, de, ctrl, bitslip, aligned);
  modport slave  (input din, output dout, de, ctrl, bitslip, aligned);
endinterface
`default_nettype wire

// File: rtl/tmds_word_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tmds_word_decode: combinational 10b TMDS word -> token flag / byte   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tmds_word_decode
  import tmds_channel_decoder_pkg::*;
(
  input  logic [9:0] i_din,
  output logic       o_is_token,
  output logic [1:0] o_token_code,
  output logic [7:0] o_q
);

  logic [7:0] w_d;

  assign w_d = i_din[9] ? ~i_din[7:0] : i_din[7:0];

  // din[8] selects whether the encoder chained bits with XOR or XNOR
  always_comb begin
    o_q    = 8'h00;
    o_q[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      o_q[i] = i_din[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end
  end

  always_comb begin
    o_is_token   = 1'b0;
    o_token_code = 2'b00;
    case (i_din)
      TMDS_CTRL_00: begin o_is_token = 1'b1; o_token_code = 2'b00; end
      TMDS_CTRL_01: begin o_is_token = 1'b1; o_token_code = 2'b01; end
      TMDS_CTRL_10: begin o_is_token = 1'b1; o_token_code = 2'b10; end
      TMDS_CTRL_11: begin o_is_token = 1'b1; o_token_code = 2'b11; end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tmds_channel_decoder: per-channel word alignment and TMDS decode     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tmds_channel_decoder
  import tmds_channel_decoder_pkg::*;
#(
  parameter int TOKEN_RUN     = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_WAIT     = 16
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  tmds_channel_decoder_if.slave bus
);

  localparam int c_run_w = $clog2(TOKEN_RUN) + 1;
  localparam int c_win_w = $clog2(SEARCH_WINDOW) + 1;
  localparam logic [c_run_w-1:0] c_run_full = c_run_w'(TOKEN_RUN);
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(SEARCH_WINDOW - 1);
  localparam logic [c_win_w-1:0] c_slip_last = c_win_w'(SLIP_WAIT - 1);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic               w_dec_tok;
  logic [1:0]         w_dec_code;
  logic [7:0]         w_dec_q;
  logic               r_s1_tok;
  logic [1:0]         r_s1_code;
  logic [7:0]         r_s1_q;
  logic [7:0]         r_dout;
  logic               r_de;
  logic [1:0]         r_ctrl;
  logic               r_aligned;
  logic [c_run_w-1:0] r_run_cnt;
  logic [c_win_w-1:0] r_win_cnt;
  logic               w_run_hit;
  logic               w_win_last;
  logic               w_bitslip;
  dec_state_t         r_state;
  dec_state_t         w_state_nxt;

  // Reset asserts asynchronously but is released on a clock edge
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  tmds_word_decode u_word_decode (
    .i_din        (bus.din),
    .o_is_token   (w_dec_tok),
    .o_token_code (w_dec_code),
    .o_q          (w_dec_q)
  );

  always_ff @(posedge pclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1_tok  <= 1'b0;
      r_s1_code <= 2'b00;
      r_s1_q    <= 8'h00;
    end else begin
      r_s1_tok  <= w_dec_tok;
      r_s1_code <= w_dec_code;
      r_s1_q    <= w_dec_q;
    end
  end

  // Output stage: ctrl keeps the last token seen across video periods
  always_ff @(posedge pclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dout <= 8'h00;
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
    end else if (!r_aligned) begin
      r_dout <= 8'h00;
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
    end else if (r_s1_tok) begin
      r_dout <= 8'h00;
      r_de   <= 1'b0;
      r_ctrl <= r_s1_code;
    end else begin
      r_dout <= r_s1_q;
      r_de   <= 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge w_rst_n) begin
    if (!w_rst_n)                       r_run_cnt <= '0;
    else if (r_state == ST_SLIP_WAIT)   r_run_cnt <= '0;
    else if (!r_s1_tok)                 r_run_cnt <= '0;
    else if (r_run_cnt != c_run_full)   r_run_cnt <= r_run_cnt + c_run_w'(1);
  end

  assign w_run_hit  = (r_run_cnt == c_run_full);
  assign w_win_last = (r_win_cnt == c_win_last);

  // One counter serves as both the search window and the slip settle timer
  always_ff @(posedge pclk or negedge w_rst_n) begin
    if (!w_rst_n)                                r_win_cnt <= '0;
    else if (w_state_nxt != r_state || w_run_hit) r_win_cnt <= '0;
    else if (r_win_cnt != c_win_last)            r_win_cnt <= r_win_cnt + c_win_w'(1);
  end

  always_ff @(posedge pclk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_SEARCH;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bitslip   = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_run_hit) begin
          w_state_nxt = ST_ALIGNED;
        end else if (w_win_last) begin
          w_bitslip   = 1'b1;
          w_state_nxt = ST_SLIP_WAIT;
        end
      end
      ST_SLIP_WAIT: begin
        if (r_win_cnt == c_slip_last) w_state_nxt = ST_SEARCH;
      end
      ST_ALIGNED: begin
        if (w_win_last && !w_run_hit) w_state_nxt = ST_SEARCH;
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  always_ff @(posedge pclk or negedge w_rst_n) begin
    if (!w_rst_n) r_aligned <= 1'b0;
    else          r_aligned <= (r_state == ST_ALIGNED);
  end

  assign bus.dout    = r_dout;
  assign bus.de      = r_de;
  assign bus.ctrl    = r_ctrl;
  assign bus.bitslip = w_bitslip;
  assign bus.aligned = r_aligned;

endmodule
`default_nettype wire
